// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file sequencer.
// Opcodes, WriteDst encoding, FSM state type, data/address widths.
package regfile_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_SWAP  = 4'd6;
    localparam logic [3:0] OP_MOV15 = 4'd7;

    typedef enum logic [1:0] {
        WD_OP1  = 2'b00,
        WD_BOTH = 2'b01,
        WD_R15  = 2'b10,
        WD_NONE = 2'b11
    } wdst_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (async low), start + dividend/divisor in; busy, quotient, remainder out.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0] src_rem, src_quo, src_dvs;
    logic [W:0]   shifted, diff;
    logic [W-1:0] nxt_rem, nxt_quo;

    // The start cycle already performs the first iteration, so the
    // result is complete W edges after start is sampled.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_quo[W-1]};
        diff    = shifted - {1'b0, src_dvs};
        if (!diff[W]) begin
            nxt_rem = diff[W-1:0];
            nxt_quo = {src_quo[W-2:0], 1'b1};
        end else begin
            nxt_rem = shifted[W-1:0];
            nxt_quo = {src_quo[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            dvs_q <= divisor;
            cnt_q <= CW'(W - 1);
        end else if (cnt_q != '0) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy      = (cnt_q != '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle initiator driving a 16x16 register file.
// Ports: instr/valid/ready in; ReadAdd1/2 + Data1/2/15 reads; WriteReg1/2/15 + WriteDst, done, err.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DIV_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [AW-1:0] ReadAdd1,
    output logic [AW-1:0] ReadAdd2,
    input  logic [DW-1:0] Data1,
    input  logic [DW-1:0] Data2,
    input  logic [DW-1:0] Data15,
    output logic [DW-1:0] WriteReg1,
    output logic [DW-1:0] WriteReg2,
    output logic [DW-1:0] WriteReg15,
    output logic [1:0]    WriteDst,
    output logic          done,
    output logic          err
);

    state_t state_q, state_d;

    logic [3:0]    op_q;
    logic [AW-1:0] a1_q, a2_q;
    logic [DW-1:0] opa_q, opb_q, r15_q;
    logic [4:0]    cnt_q;
    logic [DW-1:0] wr1_q, wr2_q, wr15_q;
    wdst_t         wd_q;
    logic          err_q;

    logic [3:0] unused_instr;
    assign unused_instr = instr[3:0];

    logic exec_last;
    assign exec_last = (state_q == S_EXEC) &&
                       ((op_q != OP_DIV) ||
                        (cnt_q == 5'(DIV_CYCLES - 1)));

    // Divider is launched from READ on the live read data so that its
    // last iteration lands before EXEC ends.
    logic          div_start;
    logic          div_busy_unused;
    logic [DW-1:0] div_quo, div_rem;

    assign div_start = (state_q == S_READ) && (op_q == OP_DIV);

    seq_divider #(.W(DW)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (Data1),
        .divisor   (Data2),
        .busy      (div_busy_unused),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (instr_valid) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: if (exec_last) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: WriteDst is forced to no-write outside WB so a reset
    // or an in-flight instruction can never cause a stray write.
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        done        = (state_q == S_WB);
        err         = (state_q == S_WB) && err_q;
        WriteDst    = (state_q == S_WB) ? wd_q : WD_NONE;
    end

    assign ReadAdd1   = a1_q;
    assign ReadAdd2   = a2_q;
    assign WriteReg1  = wr1_q;
    assign WriteReg2  = wr2_q;
    assign WriteReg15 = wr15_q;

    // Execute datapath
    logic signed [31:0] prod;
    logic [DW-1:0]      res1, res2, res15;
    wdst_t              wd;
    logic               bad;

    assign prod = $signed(opa_q) * $signed(opb_q);

    always_comb begin
        res1  = opa_q;
        res2  = opb_q;
        res15 = r15_q;
        wd    = WD_NONE;
        bad   = 1'b0;
        unique case (op_q)
            OP_ADD: begin res1 = opa_q + opb_q; wd = WD_OP1; end
            OP_SUB: begin res1 = opa_q - opb_q; wd = WD_OP1; end
            OP_AND: begin res1 = opa_q & opb_q; wd = WD_OP1; end
            OP_OR:  begin res1 = opa_q | opb_q; wd = WD_OP1; end
            OP_MUL: begin
                res1  = prod[15:0];
                res15 = prod[31:16];
                wd    = WD_R15;
            end
            OP_DIV: begin
                if (opb_q == '0) begin
                    bad = 1'b1;
                end else begin
                    res1  = div_quo;
                    res15 = div_rem;
                    wd    = WD_R15;
                end
            end
            OP_SWAP: begin
                res1 = opb_q;
                res2 = opa_q;
                wd   = WD_BOTH;
            end
            OP_MOV15: begin res1 = r15_q; wd = WD_OP1; end
            default: bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            a1_q   <= '0;
            a2_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            r15_q  <= '0;
            cnt_q  <= '0;
            wr1_q  <= '0;
            wr2_q  <= '0;
            wr15_q <= '0;
            wd_q   <= WD_NONE;
            err_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && instr_valid) begin
                op_q <= instr[15:12];
                a1_q <= instr[11:8];
                a2_q <= instr[7:4];
            end
            if (state_q == S_READ) begin
                opa_q <= Data1;
                opb_q <= Data2;
                r15_q <= Data15;
            end
            if (state_q == S_EXEC) cnt_q <= cnt_q + 5'd1;
            else                   cnt_q <= '0;
            if (exec_last) begin
                wr1_q  <= res1;
                wr2_q  <= res2;
                wr15_q <= res15;
                wd_q   <= wd;
                err_q  <= bad;
            end
        end
    end

endmodule
